// File: rtl/ins_mem_loader.sv
// ins_mem_loader
//
// Write-side companion to the instruction ROM. Accepts a program byte
// stream over a valid/ready handshake and steers each byte into one of four
// byte-wide instruction banks. The stream is big-endian per word: bank 1
// holds bits [31:24] and bank 4 holds bits [7:0]. The CPU is held in reset
// until the image is complete. A trailing partial word is padded with zero
// bytes. The number of words written is reported.
//
// Ports:
//   CLK         rising-edge clock
//   RST         synchronous, active-low reset
//   start       one-cycle pulse that begins a load (honoured in IDLE/DONE)
//   byte_valid  byte_data / byte_last are valid
//   byte_data   next program byte, MSB-first within each word
//   byte_last   marks the final byte of the image
//   byte_ready  loader accepts a byte this cycle (high only in LOAD)
//   wr_en       one-hot bank write enables; bit 3 = bank 1, bit 0 = bank 4
//   wr_addr     shared bank address {2'b00, word_idx}
//   wr_data     shared bank write data
//   busy        high while loading or padding
//   done        high once the image is complete
//   cpu_hold    CPU reset request, low only when done
//   word_count  complete words written in the current or last load
//
// WORDS is the word capacity of the banks (1..64).

module ins_mem_loader #(
    parameter int WORDS = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic [3:0] wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       cpu_hold,
    output logic [6:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PAD,
        DONE
    } state_t;

    // Index of the final word the banks can hold; its lane-3 byte ends the load.
    localparam logic [5:0] LAST_WORD = 6'(WORDS - 1);

    state_t     state;
    logic [5:0] word_idx;
    logic [1:0] lane;
    logic [3:0] lane_en;

    // Lane 0 is the most significant byte and therefore bank 1 (wr_en bit 3).
    assign lane_en = 4'b1000 >> lane;

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from the values sampled at the same edge.
    always_ff @(posedge CLK) begin
        // NOTE: the reset is sampled on the clock edge, so it sits inside
        // the clocked block rather than in the sensitivity list.
        if (!RST) begin
            state      <= IDLE;
            word_idx   <= '0;
            lane       <= '0;
            word_count <= '0;
            byte_ready <= 1'b0;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            // A write enable lasts one cycle; the branches below raise it
            // again only when a byte is written.
            wr_en <= '0;

            case (state)
                IDLE: begin
                    word_idx   <= '0;
                    lane       <= '0;
                    word_count <= '0;
                    if (start) begin
                        state      <= LOAD;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end

                LOAD: begin
                    // byte_ready is high throughout LOAD, so byte_valid alone
                    // is the accept condition here.
                    if (byte_valid) begin
                        wr_en   <= lane_en;
                        wr_addr <= {2'b00, word_idx};
                        wr_data <= byte_data;
                        lane    <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            word_idx   <= word_idx + 6'd1;
                            word_count <= word_count + 7'd1;
                            // A full word ends the load either on the image's
                            // last byte or when the banks are full.
                            if (byte_last || word_idx == LAST_WORD) begin
                                state      <= DONE;
                                byte_ready <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                cpu_hold   <= 1'b0;
                            end
                        end else if (byte_last) begin
                            state      <= PAD;
                            byte_ready <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    // One zero byte per cycle into the remaining lanes, so the
                    // pad writes directly follow the last data write.
                    wr_en   <= lane_en;
                    wr_addr <= {2'b00, word_idx};
                    wr_data <= 8'h00;
                    lane    <= lane + 2'd1;
                    if (lane == 2'd3) begin
                        word_idx   <= word_idx + 6'd1;
                        word_count <= word_count + 7'd1;
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
                    end
                end

                DONE: begin
                    // word_count keeps reporting the last load until a restart.
                    if (start) begin
                        state      <= LOAD;
                        word_idx   <= '0;
                        lane       <= '0;
                        word_count <= '0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule
